// File: rtl/irq_controller.sv
// irq_controller: CPU-side responder for the external IRQ lines.
//
// Captures rising edges on IRQ into pending bits and reports them on IRW. It
// picks the highest pending source above the level now being serviced, and
// when the pipeline allows, it issues a one-cycle flush/redirect (irq_take)
// to that source's handler vector. At the same time it pushes the resume PC
// onto a small nested return-address stack. Each eret pops one level and
// issues a one-cycle return redirect (irq_ret) with the saved PC.
//
// Ports:
//   clk         system clock, rising edge
//   rst         asynchronous active-low reset
//   IRQ         external request lines, index NIRQ-1 has the highest priority
//   stall       pipeline hold; blocks a take while high
//   take_ok     pipeline is at a precise boundary
//   epc_in      resume PC, pushed when a take happens this cycle
//   eret        return-from-interrupt retiring (one-cycle pulse)
//   irq_take    one-cycle flush/redirect request
//   irq_vector  handler address, valid while irq_take is high
//   irq_ret     one-cycle return redirect
//   epc_out     return address, valid while irq_ret is high
//   IRW         pending (waiting) request bits
//   in_service  levels currently being serviced
module irq_controller #(
  parameter int unsigned      WIDTH      = 32,
  parameter int unsigned      NIRQ       = 3,
  parameter logic [WIDTH-1:0] VEC_BASE   = 32'h0000_3000,
  parameter logic [WIDTH-1:0] VEC_STRIDE = 32'h0000_0100
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NIRQ-1:0]  IRQ,
  input  logic             stall,
  input  logic             take_ok,
  input  logic [WIDTH-1:0] epc_in,
  input  logic             eret,
  output logic             irq_take,
  output logic [WIDTH-1:0] irq_vector,
  output logic             irq_ret,
  output logic [WIDTH-1:0] epc_out,
  output logic [NIRQ-1:0]  IRW,
  output logic [NIRQ-1:0]  in_service
);

  localparam int unsigned IdxW = (NIRQ > 1) ? $clog2(NIRQ) : 1;
  localparam int unsigned SpW  = $clog2(NIRQ + 1);
  localparam logic [NIRQ-1:0] OneHot0 = {{(NIRQ-1){1'b0}}, 1'b1};

  logic [NIRQ-1:0]  irq_prev_q;
  logic             armed_q;
  logic [NIRQ-1:0]  pending_q, pending_d;
  logic [NIRQ-1:0]  in_service_q, in_service_d;
  logic [WIDTH-1:0] stack_q [NIRQ];
  logic [SpW-1:0]   sp_q, sp_d;
  logic             irq_take_q;
  logic             irq_ret_q;
  logic [WIDTH-1:0] irq_vector_q;
  logic [WIDTH-1:0] epc_out_q;

  logic             lvl_valid;
  logic [IdxW-1:0]  lvl_idx;
  logic             cand_valid;
  logic [IdxW-1:0]  cand_idx;
  logic [NIRQ-1:0]  rise;
  logic             ret_do;
  logic             take_do;
  logic [NIRQ-1:0]  take_mask;
  logic [NIRQ-1:0]  lvl_mask;
  logic [WIDTH-1:0] vector_d;
  logic [WIDTH-1:0] pop_val;

  // Current level L: the highest in-service bit.
  always_comb begin
    lvl_valid = 1'b0;
    lvl_idx   = '0;
    for (int unsigned i = 0; i < NIRQ; i++) begin
      if (in_service_q[i]) begin
        lvl_valid = 1'b1;
        lvl_idx   = IdxW'(i);
      end
    end
  end

  // Candidate: the highest pending source strictly above L.
  always_comb begin
    cand_valid = 1'b0;
    cand_idx   = '0;
    for (int unsigned i = 0; i < NIRQ; i++) begin
      if (pending_q[i] && (!lvl_valid || (IdxW'(i) > lvl_idx))) begin
        cand_valid = 1'b1;
        cand_idx   = IdxW'(i);
      end
    end
  end

  // Saved PC for the current top of stack.
  always_comb begin
    pop_val = '0;
    for (int unsigned i = 0; i < NIRQ; i++) begin
      if (SpW'(i) == (sp_q - SpW'(1))) begin
        pop_val = stack_q[i];
      end
    end
  end

  always_comb begin
    // After reset, the first edge only primes irq_prev_q. A line that is
    // already held high is therefore not mistaken for a fresh request.
    rise      = IRQ & ~irq_prev_q & {NIRQ{armed_q}};
    ret_do    = eret & (|in_service_q);
    // Any eret blocks the take, even one ignored for lack of a level. The
    // previous cycle's redirect also blocks it, so no two redirects touch.
    take_do   = cand_valid & take_ok & ~stall & ~eret & ~irq_take_q & ~irq_ret_q;
    take_mask = take_do ? (OneHot0 << cand_idx) : '0;
    lvl_mask  = ret_do ? (OneHot0 << lvl_idx) : '0;
    vector_d  = VEC_BASE + (WIDTH'(cand_idx) * VEC_STRIDE);

    // A new edge on the source being taken re-pends it.
    pending_d    = (pending_q & ~take_mask) | rise;
    in_service_d = (in_service_q | take_mask) & ~lvl_mask;

    sp_d = sp_q;
    if (take_do) begin
      sp_d = sp_q + SpW'(1);
    end else if (ret_do) begin
      sp_d = sp_q - SpW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      irq_prev_q   <= '0;
      armed_q      <= 1'b0;
      pending_q    <= '0;
      in_service_q <= '0;
      sp_q         <= '0;
      irq_take_q   <= 1'b0;
      irq_ret_q    <= 1'b0;
      irq_vector_q <= '0;
      epc_out_q    <= '0;
      for (int unsigned i = 0; i < NIRQ; i++) begin
        stack_q[i] <= '0;
      end
    end else begin
      irq_prev_q   <= IRQ;
      armed_q      <= 1'b1;
      pending_q    <= pending_d;
      in_service_q <= in_service_d;
      sp_q         <= sp_d;
      irq_take_q   <= take_do;
      irq_ret_q    <= ret_do;
      if (take_do) begin
        irq_vector_q <= vector_d;
      end
      if (ret_do) begin
        epc_out_q <= pop_val;
      end
      for (int unsigned i = 0; i < NIRQ; i++) begin
        if (take_do && (sp_q == SpW'(i))) begin
          stack_q[i] <= epc_in;
        end
      end
    end
  end

  assign irq_take   = irq_take_q;
  assign irq_ret    = irq_ret_q;
  assign irq_vector = irq_vector_q;
  assign epc_out    = epc_out_q;
  assign IRW        = pending_q;
  assign in_service = in_service_q;

endmodule
